diag_recip_div: RTL



---
 rtl/cvsd_fixed_pkg.sv | 52 +++++
 rtl/recip_div_step.sv | 27 ++
 rtl/diag_recip_div.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cvsd_fixed_pkg.sv
// Shared fixed-point constants, FSM state type and saturation helper
// for the reciprocal datapath.
package cvsd_fixed_pkg;

  localparam int Q4_12_W   = 16;
  localparam int Q2_14_W   = 16;
  localparam int DIV_STEPS = 27;

  localparam logic [15:0] POS_MAX16 = 16'h7FFF;
  localparam logic [15:0] NEG_MAX16 = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [15:0] recip;
    logic        sat;
    logic        div_zero;
  } recip_res_t;

  // Maps the unsigned quotient magnitude onto signed Q2.14 with clipping.
  function automatic recip_res_t recip_saturate(input logic neg, input logic zero,
                                                input logic [26:0] q);
    recip_res_t res;
    res.recip    = 16'h0000;
    res.sat      = 1'b0;
    res.div_zero = 1'b0;
    if (zero) begin
      res.recip    = POS_MAX16;
      res.div_zero = 1'b1;
    end else if (!neg) begin
      if (q > 27'd32767) begin
        res.recip = POS_MAX16;
        res.sat   = 1'b1;
      end else begin
        res.recip = q[15:0];
      end
    end else begin
      if (q > 27'd32768) begin
        res.recip = NEG_MAX16;
        res.sat   = 1'b1;
      end else begin
        res.recip = 16'h0000 - q[15:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/recip_div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module recip_div_step (
  input  logic [16:0] i_rem,
  input  logic        i_bit,
  input  logic [16:0] i_divisor,
  output logic [16:0] o_rem,
  output logic        o_qbit
);

  logic [17:0] w_trial;
  logic [16:0] w_diff;

  always_comb begin
    w_trial = {i_rem, i_bit};
    // Difference is only used when trial >= divisor, so it fits in 17 bits.
    w_diff  = w_trial[16:0] - i_divisor;
    if (w_trial >= {1'b0, i_divisor}) begin
      o_rem  = w_diff;
      o_qbit = 1'b1;
    end else begin
      o_rem  = w_trial[16:0];
      o_qbit = 1'b0;
    end
  end

endmodule

// File: rtl/diag_recip_div.sv
// Sequential reciprocal of a signed Q4.12 diagonal element, producing a
// saturated Q2.14 result via bit-serial restoring division of 2^26 by |a|.
module diag_recip_div
  import cvsd_fixed_pkg::*;
#(
  parameter int IDX_W  = 4,
  parameter int DATA_W = Q4_12_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] diag,
  input  logic [IDX_W-1:0]  in_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] recip,
  output logic [IDX_W-1:0]  out_idx,
  output logic              sat,
  output logic              div_zero
);

  localparam logic [4:0] CNT_START = 5'(DIV_STEPS - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_sign;
  logic               r_zero;
  logic [16:0]        r_divisor;
  logic [IDX_W-1:0]   r_idx;
  logic [4:0]         r_cnt;
  logic [16:0]        r_rem;
  logic [25:0]        r_quot;
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_recip;
  logic [IDX_W-1:0]   r_out_idx;
  logic               r_sat;
  logic               r_div_zero;

  logic [16:0]        w_abs;
  logic [16:0]        w_rem_nxt;
  logic               w_qbit;
  recip_res_t         w_res;

  // Magnitude as 17 bits so that -8.0 (0x8000) becomes 32768 without overflow.
  assign w_abs = diag[DATA_W-1] ? ({1'b0, ~diag} + 17'd1) : {1'b0, diag};

  recip_div_step u_step (
    .i_rem     (r_rem),
    .i_bit     (r_cnt == CNT_START),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_nxt),
    .o_qbit    (w_qbit)
  );

  assign w_res = recip_saturate(r_sign, r_zero, {r_quot, w_qbit});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) w_state_nxt = CALC;
        else          w_state_nxt = IDLE;
      end
      CALC: begin
        if (r_cnt == 5'd0) w_state_nxt = DONE;
        else               w_state_nxt = CALC;
      end
      DONE: begin
        if (r_out_valid && out_ready) w_state_nxt = IDLE;
        else                          w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign      <= 1'b0;
      r_zero      <= 1'b0;
      r_divisor   <= 17'd0;
      r_idx       <= '0;
      r_cnt       <= 5'd0;
      r_rem       <= 17'd0;
      r_quot      <= 26'd0;
      r_out_valid <= 1'b0;
      r_recip     <= '0;
      r_out_idx   <= '0;
      r_sat       <= 1'b0;
      r_div_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign    <= diag[DATA_W-1];
            r_zero    <= (diag == 16'h0000);
            r_divisor <= w_abs;
            r_idx     <= in_idx;
            r_cnt     <= CNT_START;
            r_rem     <= 17'd0;
            r_quot    <= 26'd0;
          end
        end
        CALC: begin
          r_rem  <= w_rem_nxt;
          r_quot <= {r_quot[24:0], w_qbit};
          r_cnt  <= r_cnt - 5'd1;
          // Last step: the final quotient bit comes straight from the step logic.
          if (r_cnt == 5'd0) begin
            r_recip    <= w_res.recip;
            r_sat      <= w_res.sat;
            r_div_zero <= w_res.div_zero;
            r_out_idx  <= r_idx;
          end
        end
        DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign recip     = r_recip;
  assign out_idx   = r_out_idx;
  assign sat       = r_sat;
  assign div_zero  = r_div_zero;

endmodule
